// File: rtl/bcd_conv_sched.sv
// Shared BCD-to-binary converter: round-robin intake from two requesters,
// one Horner step (acc*10 + digit) per clock, result held behind valid/ready.
module bcd_conv_sched #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid0,
    input  logic [N-1:0] req_A0,
    input  logic         req_sign0,
    output logic         req_ready0,
    input  logic         req_valid1,
    input  logic [N-1:0] req_A1,
    input  logic         req_sign1,
    output logic         req_ready1,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         res_err,
    output logic         busy
);
    localparam int ND = N / 4;
    localparam int PW = (ND > 1) ? $clog2(ND) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  a_reg;
    logic          sign_reg;
    logic          id_reg;
    logic          last_grant;
    logic [N-1:0]  acc;
    logic          err;
    logic [PW-1:0] ptr;

    logic          grant;
    logic          take;
    logic [N-1:0]  take_a;
    logic          take_sign;
    logic [PW-1:0] start_ptr;
    logic [3:0]    nib;
    logic          nib_bad;
    logic [N-1:0]  acc_next;
    logic [N-1:0]  acc_final;

    // Contention goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req_valid0 && req_valid1) begin
            grant = ~last_grant;
        end else if (req_valid1) begin
            grant = 1'b1;
        end
    end

    assign take       = (state == IDLE) && !rst && (req_valid0 || req_valid1);
    assign req_ready0 = take && !grant;
    assign req_ready1 = take && grant;

    assign take_a    = grant ? req_A1 : req_A0;
    assign take_sign = grant ? req_sign1 : req_sign0;
    // Signed operands give up their top digit to the sign flag.
    assign start_ptr = take_sign ? PW'(ND - 2) : PW'(ND - 1);

    assign nib       = 4'(a_reg >> {ptr, 2'b00});
    assign nib_bad   = (nib > 4'd9);
    assign acc_next  = (acc << 3) + (acc << 1) + {{(N-4){1'b0}}, nib};
    assign acc_final = (sign_reg && a_reg[N-4]) ? -acc_next : acc_next;

    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            sign_reg   <= 1'b0;
            id_reg     <= 1'b0;
            last_grant <= 1'b1;
            acc        <= '0;
            err        <= 1'b0;
            ptr        <= '0;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        a_reg      <= take_a;
                        sign_reg   <= take_sign;
                        id_reg     <= grant;
                        last_grant <= grant;
                        acc        <= '0;
                        err        <= 1'b0;
                        ptr        <= start_ptr;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    err <= err | nib_bad;
                    ptr <= ptr - PW'(1);
                    if (ptr == '0) begin
                        res_data <= acc_final;
                        res_err  <= err | nib_bad;
                        res_id   <= id_reg;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
